// File: rtl/seg_sched_pkg.sv
// Shared types for the segment-display value scheduler.
// SEG_SCHED_PIN_EN adds the PINNED state used by the pin override.
package seg_sched_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SHOW   = 2'd1
`ifdef SEG_SCHED_PIN_EN
        ,ST_PINNED = 2'd2
`endif
    } sched_state_e;

    localparam logic [15:0] BLANK_VALUE = 16'h0000;

endpackage

// File: rtl/seg_rr_next.sv
// Round-robin finder: first set bit of valid_i strictly after cur_i, wrapping;
// cur_i itself is considered last so a lone valid source reselects itself.
module seg_rr_next #(
    parameter int N  = 4,
    parameter int IW = $clog2(N)
) (
    input  logic [N-1:0]  valid_i,
    input  logic [IW-1:0] cur_i,
    output logic [IW-1:0] nxt_o,
    output logic          found_o
);

    always_comb begin
        nxt_o   = cur_i;
        found_o = |valid_i;
        // Walk farthest-first so the nearest hit is the one that sticks.
        for (int k = N; k >= 1; k--) begin
            if (valid_i[(int'(cur_i) + k) % N]) nxt_o = IW'((int'(cur_i) + k) % N);
        end
    end

endmodule

// File: rtl/seg_value_sched.sv
// Time-slices NUM_SRC requester values onto one registered display value.
// Define SEG_SCHED_PIN_EN to add pin_req/pin_sel and the PINNED override.
module seg_value_sched
    import seg_sched_pkg::*;
#(
    parameter int NUM_SRC     = 4,
    parameter int HOLD_CYCLES = 100_000_000
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [NUM_SRC*16-1:0]      src_value,
    input  logic [NUM_SRC-1:0]         src_valid,
`ifdef SEG_SCHED_PIN_EN
    input  logic                       pin_req,
    input  logic [$clog2(NUM_SRC)-1:0] pin_sel,
`endif
    output logic [15:0]                value,
    output logic [$clog2(NUM_SRC)-1:0] src_idx,
    output logic                       active
);

    localparam int IW = $clog2(NUM_SRC);
    localparam int CW = $clog2(HOLD_CYCLES);
    localparam logic [CW-1:0] CNT_LAST = CW'(HOLD_CYCLES - 1);

    sched_state_e  state_q, state_d;
    logic [IW-1:0] sel_q, sel_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [15:0]   value_q, value_d;

    logic [IW-1:0] rr_cur, rr_nxt;
    logic          rr_found;

    // From IDLE, searching after the top index yields the lowest valid index.
    assign rr_cur = (state_q == ST_IDLE) ? IW'(NUM_SRC - 1) : sel_q;

    seg_rr_next #(.N(NUM_SRC), .IW(IW)) u_rr (
        .valid_i (src_valid),
        .cur_i   (rr_cur),
        .nxt_o   (rr_nxt),
        .found_o (rr_found)
    );

`ifdef SEG_SCHED_PIN_EN
    logic [IW-1:0] pin_tgt;
    assign pin_tgt = (int'(pin_sel) < NUM_SRC) ? pin_sel : sel_q;
`endif

    always_comb begin
        state_d = state_q;
        sel_d   = sel_q;
        cnt_d   = cnt_q;
        case (state_q)
            ST_IDLE: begin
                if (rr_found) begin
                    state_d = ST_SHOW;
                    sel_d   = rr_nxt;
                    cnt_d   = '0;
                end
            end
            ST_SHOW: begin
                if (!rr_found) begin
                    state_d = ST_IDLE;
                end else if (!src_valid[sel_q] || cnt_q == CNT_LAST) begin
                    // Expiry and drop together still move exactly one step.
                    sel_d = rr_nxt;
                    cnt_d = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
`ifdef SEG_SCHED_PIN_EN
            ST_PINNED: begin
                cnt_d = '0;
                if (!rr_found) begin
                    state_d = ST_IDLE;
                end else begin
                    state_d = ST_SHOW;
                    if (!src_valid[sel_q]) sel_d = rr_nxt;
                end
            end
`endif
            default: state_d = ST_IDLE;
        endcase
`ifdef SEG_SCHED_PIN_EN
        if (pin_req) begin
            state_d = ST_PINNED;
            sel_d   = pin_tgt;
            cnt_d   = cnt_q;
        end
`endif
    end

    assign value_d = (state_d == ST_IDLE) ? BLANK_VALUE : src_value[16*sel_d +: 16];

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            sel_q   <= '0;
            cnt_q   <= '0;
            value_q <= BLANK_VALUE;
        end else begin
            state_q <= state_d;
            sel_q   <= sel_d;
            cnt_q   <= cnt_d;
            value_q <= value_d;
        end
    end

    // value feeds seg_display.value as-is; digit scanning lives there.
    assign value   = value_q;
    assign src_idx = sel_q;
    assign active  = (state_q != ST_IDLE);

endmodule

// File: tb/tb_seg_value_sched.sv
// Randomized and directed bench for seg_value_sched against a rule-level model.
module tb_seg_value_sched;

    localparam int NS   = 4;
    localparam int HOLD = 8;

    logic        clk = 1'b0;
    logic        rst;
    logic [63:0] src_value;
    logic [3:0]  src_valid;
    logic [15:0] value;
    logic [1:0]  src_idx;
    logic        active;
`ifdef SEG_SCHED_PIN_EN
    logic        pin_req;
    logic [1:0]  pin_sel;
`endif

    int total = 0;
    int bad   = 0;

    // Reference model state: what should be on the outputs after each edge.
    bit          m_act;
    bit          m_pin;
    logic [1:0]  m_idx;
    int          m_age;
    logic [15:0] m_val;

    seg_value_sched #(.NUM_SRC(NS), .HOLD_CYCLES(HOLD)) dut (
        .clk       (clk),
        .rst       (rst),
        .src_value (src_value),
        .src_valid (src_valid),
`ifdef SEG_SCHED_PIN_EN
        .pin_req   (pin_req),
        .pin_sel   (pin_sel),
`endif
        .value     (value),
        .src_idx   (src_idx),
        .active    (active)
    );

    always #5 clk = ~clk;

    function automatic logic [1:0] next_after(input logic [1:0] cur, input logic [3:0] v);
        for (int k = 1; k <= NS; k++)
            if (v[(int'(cur) + k) % NS]) return 2'((int'(cur) + k) % NS);
        return cur;
    endfunction

    function automatic logic [15:0] data_of(input logic [1:0] i);
        logic [63:0] d;
        d = src_value;
        return d[16*i +: 16];
    endfunction

    // One clock edge: update the model from the inputs present at the edge.
    task automatic tick();
        @(posedge clk);
        if (rst) begin
            m_act = 0; m_pin = 0; m_idx = 0; m_age = 0;
        end
`ifdef SEG_SCHED_PIN_EN
        else if (pin_req) begin
            m_pin = 1; m_act = 1; m_idx = pin_sel;
        end
`endif
        else if (src_valid == 4'b0000) begin
            m_act = 0; m_pin = 0;
        end else if (!m_act) begin
            m_act = 1; m_age = 0;
            m_idx = next_after(2'd3, src_valid);
        end else if (m_pin) begin
            m_pin = 0; m_age = 0;
            if (!src_valid[m_idx]) m_idx = next_after(m_idx, src_valid);
        end else if (!src_valid[m_idx] || m_age == HOLD - 1) begin
            m_idx = next_after(m_idx, src_valid);
            m_age = 0;
        end else begin
            m_age++;
        end
        m_val = m_act ? data_of(m_idx) : 16'h0000;
        #1;
    endtask

    task automatic set_ramp();
        for (int i = 0; i < NS; i++) src_value[16*i +: 16] = 16'(32'h1111 * (i + 1));
    endtask

    task automatic test_reset();
        rst = 1; src_valid = 4'b1111; set_ramp();
        tick(); tick();
        total++;
        if (value !== 16'h0000 || src_idx !== 2'd0 || active !== 1'b0) begin
            bad++;
            $display("FAIL reset: value=%h idx=%0d act=%b, want 0000 0 0", value, src_idx, active);
        end
        src_valid = 4'b0000;
        tick();
        rst = 0;
    endtask

    task automatic test_rotate();
        logic [1:0]  ei;
        logic [15:0] ev;
        set_ramp(); src_valid = 4'b1111;
        for (int k = 1; k <= 40; k++) begin
            tick();
            ei = 2'(((k - 1) / HOLD) % NS);
            ev = 16'(32'h1111 * (ei + 1));
            total++;
            if (src_idx !== ei || value !== ev || active !== 1'b1 || m_idx !== ei) begin
                bad++;
                $display("FAIL rotate k=%0d: idx=%0d value=%h act=%b, want %0d %h 1", k, src_idx, value, active, ei, ev);
            end
        end
    endtask

    task automatic test_single();
        src_valid = 4'b0100;
        for (int k = 0; k < 30; k++) begin
            tick();
            total++;
            if (src_idx !== 2'd2 || value !== 16'h3333 || active !== 1'b1) begin
                bad++;
                $display("FAIL single k=%0d: idx=%0d value=%h act=%b, want 2 3333 1", k, src_idx, value, active);
            end
        end
    endtask

    task automatic test_drop();
        int n;
        src_valid = 4'b1111;
        n = 0;
        while (!(m_idx == 2'd1 && m_age == 3) && n < 100) begin
            tick(); n++;
        end
        total++;
        if (n >= 100 || src_idx !== 2'd1) begin
            bad++;
            $display("FAIL drop_setup: idx=%0d after %0d cycles, want 1", src_idx, n);
        end
        src_valid = 4'b1001;
        for (int k = 0; k < HOLD; k++) begin
            tick();
            total++;
            if (src_idx !== 2'd3 || value !== 16'h4444) begin
                bad++;
                $display("FAIL drop k=%0d: idx=%0d value=%h, want 3 4444", k, src_idx, value);
            end
        end
        tick();
        total++;
        if (src_idx !== 2'd0 || value !== 16'h1111) begin
            bad++;
            $display("FAIL drop_wrap: idx=%0d value=%h, want 0 1111", src_idx, value);
        end
    endtask

    task automatic test_idle();
        src_valid = 4'b0000;
        tick(); tick();
        total++;
        if (value !== 16'h0000 || active !== 1'b0) begin
            bad++;
            $display("FAIL idle: value=%h act=%b, want 0000 0", value, active);
        end
        src_valid = 4'b0010;
        tick();
        total++;
        if (src_idx !== 2'd1 || value !== 16'h2222 || active !== 1'b1) begin
            bad++;
            $display("FAIL idle_exit: idx=%0d value=%h act=%b, want 1 2222 1", src_idx, value, active);
        end
    endtask

    task automatic test_reset_mid();
        int n;
        src_valid = 4'b1111;
        n = 0;
        while (!(m_idx == 2'd2 && m_age == 4) && n < 100) begin
            tick(); n++;
        end
        rst = 1;
        tick();
        total++;
        if (n >= 100 || value !== 16'h0000 || src_idx !== 2'd0 || active !== 1'b0) begin
            bad++;
            $display("FAIL reset_mid: value=%h idx=%0d act=%b n=%0d, want 0000 0 0", value, src_idx, active, n);
        end
        rst = 0;
        tick();
        total++;
        if (src_idx !== 2'd0 || value !== 16'h1111 || active !== 1'b1) begin
            bad++;
            $display("FAIL reset_release: idx=%0d value=%h act=%b, want 0 1111 1", src_idx, value, active);
        end
    endtask

`ifdef SEG_SCHED_PIN_EN
    task automatic test_pin();
        src_valid = 4'b0001; pin_sel = 2'd3; pin_req = 1;
        for (int k = 0; k < 30; k++) begin
            tick();
            total++;
            if (src_idx !== 2'd3 || value !== 16'h4444 || active !== 1'b1) begin
                bad++;
                $display("FAIL pin k=%0d: idx=%0d value=%h act=%b, want 3 4444 1", k, src_idx, value, active);
            end
        end
        pin_req = 0;
        tick();
        total++;
        if (src_idx !== 2'd0 || value !== 16'h1111) begin
            bad++;
            $display("FAIL pin_release: idx=%0d value=%h, want 0 1111", src_idx, value);
        end
    endtask
`endif

    task automatic test_random();
        for (int k = 0; k < 500; k++) begin
            if ($urandom_range(0, 9) == 0) src_valid = 4'($urandom);
            src_value = {$urandom, $urandom};
            rst = ($urandom_range(0, 59) == 0);
`ifdef SEG_SCHED_PIN_EN
            if ($urandom_range(0, 19) == 0) pin_req = ~pin_req;
            pin_sel = 2'($urandom);
`endif
            tick();
            total++;
            if (value !== m_val || src_idx !== m_idx || active !== m_act) begin
                bad++;
                $display("FAIL random k=%0d: value=%h idx=%0d act=%b, want %h %0d %b",
                         k, value, src_idx, active, m_val, m_idx, m_act);
            end
        end
        rst = 0;
    endtask

    initial begin
        rst = 1; src_valid = '0; src_value = '0;
`ifdef SEG_SCHED_PIN_EN
        pin_req = 0; pin_sel = '0;
`endif
        m_act = 0; m_pin = 0; m_idx = 0; m_age = 0; m_val = '0;
        test_reset();
        test_rotate();
        test_single();
        test_drop();
        test_idle();
        test_reset_mid();
`ifdef SEG_SCHED_PIN_EN
        test_pin();
`endif
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
